// File: rtl/adc_capture_ctrl.sv
// Capture sequencer for the ADC trigger/sum datapath: clear, arm, wait for a
// fresh trigger edge, then gate exactly one record onto the AXI-Stream master.
module adc_capture_ctrl #(
    parameter int CNT_WIDTH  = 32,
    parameter int CLR_CYCLES = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 cfg_start,
    input  logic                 cfg_abort,
    input  logic                 cfg_rearm,
    input  logic [CNT_WIDTH-1:0] cfg_record_len,
    input  logic [CNT_WIDTH-1:0] cfg_timeout,
    input  logic                 trig_active,
    input  logic                 s_axis_tvalid,
    input  logic [63:0]          s_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic [63:0]          m_axis_tdata,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 reset_trigger,
    output logic                 reset_max_sum,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [2:0]           sts_state,
    output logic [15:0]          sts_records,
    output logic [CNT_WIDTH-1:0] sts_dropped,
    output logic                 sts_timeout,
    output logic                 sts_short
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ARM     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int                   CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0]     CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t               state_q;
    logic [CLR_W-1:0]     clr_cnt_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] timeout_q;
    logic [CNT_WIDTH-1:0] wait_q;
    logic [CNT_WIDTH-1:0] beat_q;
    logic [CNT_WIDTH-1:0] dropped_q;
    logic [15:0]          records_q;
    logic                 trig_prev_q;
    logic                 clr_q;
    logic                 done_q;
    logic                 timeout_flag_q;
    logic                 short_q;
    logic [63:0]          tdata_q;

    logic                 in_capture;
    logic                 trig_edge;
    logic                 accept;
    logic                 drop;
    logic                 last_beat;
    logic                 arm_expired;
    logic                 record_full;
    logic                 enter_clear;
    logic [CNT_WIDTH-1:0] len_d;

    always_comb begin
        in_capture  = (state_q == CAPTURE);
        trig_edge   = trig_active & ~trig_prev_q;
        accept      = s_axis_tvalid & m_axis_tready;
        drop        = s_axis_tvalid & ~m_axis_tready;
        last_beat   = (beat_q == len_q - CNT_ONE);
        record_full = accept & last_beat;
        arm_expired = (timeout_q != '0) && (wait_q == timeout_q - CNT_ONE);
        enter_clear = !cfg_abort &&
                      (((state_q == IDLE) && cfg_start) || ((state_q == DONE) && cfg_rearm));
        len_d       = (cfg_record_len == '0) ? CNT_ONE : cfg_record_len;
    end

    // trig_prev is forced high through CLEAR so a level left over from the
    // previous record can never look like a fresh rising edge in ARM.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q        <= IDLE;
            clr_cnt_q      <= '0;
            len_q          <= '0;
            timeout_q      <= '0;
            wait_q         <= '0;
            beat_q         <= '0;
            dropped_q      <= '0;
            records_q      <= '0;
            trig_prev_q    <= 1'b0;
            clr_q          <= 1'b0;
            done_q         <= 1'b0;
            timeout_flag_q <= 1'b0;
            short_q        <= 1'b0;
            tdata_q        <= '0;
        end else begin
            done_q      <= 1'b0;
            trig_prev_q <= (state_q == CLEAR) ? 1'b1 : trig_active;
            if (in_capture) begin
                tdata_q <= s_axis_tdata;
            end

            if (cfg_abort) begin
                state_q <= IDLE;
                clr_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cfg_start) begin
                            state_q <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (clr_cnt_q == CLR_LAST) begin
                            state_q <= ARM;
                            clr_q   <= 1'b0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 1'b1;
                        end
                    end
                    ARM: begin
                        if (trig_edge) begin
                            state_q <= CAPTURE;
                        end else if (arm_expired) begin
                            state_q        <= DONE;
                            done_q         <= 1'b1;
                            timeout_flag_q <= 1'b1;
                            short_q        <= 1'b0;
                        end else if (wait_q != CNT_MAX) begin
                            wait_q <= wait_q + CNT_ONE;
                        end
                    end
                    CAPTURE: begin
                        if (drop && (dropped_q != CNT_MAX)) begin
                            dropped_q <= dropped_q + CNT_ONE;
                        end
                        if (record_full || !trig_active) begin
                            state_q        <= DONE;
                            done_q         <= 1'b1;
                            timeout_flag_q <= 1'b0;
                            short_q        <= !record_full;
                            if (records_q != 16'hFFFF) begin
                                records_q <= records_q + 16'd1;
                            end
                        end else if (accept) begin
                            beat_q <= beat_q + CNT_ONE;
                        end
                    end
                    DONE: begin
                        state_q <= cfg_rearm ? CLEAR : IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase

                // Record config is sampled only here, so later register writes
                // cannot disturb a sequence that is already running.
                if (enter_clear) begin
                    clr_q     <= 1'b1;
                    clr_cnt_q <= '0;
                    len_q     <= len_d;
                    timeout_q <= cfg_timeout;
                    wait_q    <= '0;
                    beat_q    <= '0;
                    if (state_q == IDLE) begin
                        timeout_flag_q <= 1'b0;
                        short_q        <= 1'b0;
                        dropped_q      <= '0;
                    end
                end
            end
        end
    end

    assign m_axis_tvalid = in_capture & s_axis_tvalid;
    assign m_axis_tdata  = in_capture ? s_axis_tdata : tdata_q;
    assign m_axis_tlast  = in_capture & last_beat;
    assign reset_trigger = clr_q;
    assign reset_max_sum = clr_q;
    assign busy          = (state_q != IDLE);
    assign done_pulse    = done_q;
    assign sts_state     = state_q;
    assign sts_records   = records_q;
    assign sts_dropped   = dropped_q;
    assign sts_timeout   = timeout_flag_q;
    assign sts_short     = short_q;

endmodule
